// File: rtl/ysyx_22041412_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, zero word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ysyx_22041412_lsu_pkg;

    // RISC-V load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // RISC-V store funct3 encodings (only the low two bits carry the size)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Never a legal load or store
    localparam logic [2:0] F3_BAD = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CACHE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [63:0] ZERO_WORD = 64'd0;

endpackage

// File: rtl/ysyx_22041412_lsu_if.sv
// Bundle of the pipeline request/response and Dcache handshakes around the LSU.
// Latency: n/a (wires only).
// Backpressure: valid/ready on request, response and Dcache channels.
// Ports: slave modport = LSU view; master modport = pipeline + Dcache environment view.
interface ysyx_22041412_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // pipeline request
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_wen_i;
    logic [2:0]            req_func3_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    // pipeline response
    logic                  resp_valid_o;
    logic                  resp_ready_i;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic                  resp_fault_o;
    // Dcache side
    logic                  dc_valid_o;
    logic                  dc_ready_i;
    logic                  dc_wen_o;
    logic [ADDR_WIDTH-1:0] dc_addr_o;
    logic [DATA_WIDTH-1:0] dc_wdata_o;
    logic [STRB_WIDTH-1:0] dc_wstrb_o;
    logic [DATA_WIDTH-1:0] dc_rdata_i;

    modport slave (
        input  req_valid_i, req_wen_i, req_func3_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output resp_valid_o, resp_rdata_o, resp_fault_o,
        input  resp_ready_i,
        output dc_valid_o, dc_wen_o, dc_addr_o, dc_wdata_o, dc_wstrb_o,
        input  dc_ready_i, dc_rdata_i
    );

    modport master (
        output req_valid_i, req_wen_i, req_func3_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  resp_valid_o, resp_rdata_o, resp_fault_o,
        output resp_ready_i,
        input  dc_valid_o, dc_wen_o, dc_addr_o, dc_wdata_o, dc_wstrb_o,
        output dc_ready_i, dc_rdata_i
    );

endinterface

// File: rtl/ysyx_22041412_lsu_align.sv
// Byte-lane alignment: store strobe/shift, load shift/extend, misalign/illegal-width detection.
// Latency: purely combinational.
// Backpressure: none (no state).
// Ports: func3/off describe the access; wdata/rdata_raw in; wstrb/wdata_sh/rdata_ext/fault out.
module ysyx_22041412_lsu_align
    import ysyx_22041412_lsu_pkg::*;
#(
    parameter int  DATA_WIDTH = 64,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int OFF_WIDTH  = $clog2(STRB_WIDTH)
) (
    input  logic [2:0]            func3,
    input  logic [OFF_WIDTH-1:0]  off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata_raw,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic [DATA_WIDTH-1:0] wdata_sh,
    output logic [DATA_WIDTH-1:0] rdata_ext,
    output logic                  fault
);

    logic [1:0]                    size_log;
    logic [STRB_WIDTH-1:0]         lane_mask;
    logic [OFF_WIDTH-1:0]          align_mask;
    logic [$clog2(DATA_WIDTH)-1:0] bit_off;
    logic [DATA_WIDTH-1:0]         shifted;
    logic                          misaligned;
    logic                          illegal;

    always_comb begin
        size_log   = func3[1:0];
        bit_off    = {off, 3'b000};
        lane_mask  = STRB_WIDTH'(8'hFF);
        unique case (size_log)
            F3_SB[1:0]: lane_mask = STRB_WIDTH'(8'h01);
            F3_SH[1:0]: lane_mask = STRB_WIDTH'(8'h03);
            F3_SW[1:0]: lane_mask = STRB_WIDTH'(8'h0F);
            default:    lane_mask = STRB_WIDTH'(8'hFF);
        endcase

        // size-1 as an offset mask: any offset bit under it means misaligned
        align_mask = OFF_WIDTH'((4'd1 << size_log) - 4'd1);
        misaligned = |(off & align_mask);

        // a doubleword (and lwu, whose only point is zero-extending into 64 bits)
        // cannot be served by a 32-bit data bus
        illegal = (func3 == F3_BAD) ||
                  ((STRB_WIDTH < 8) && ((size_log == F3_SD[1:0]) || (func3 == F3_LWU)));
        fault   = misaligned | illegal;

        wstrb    = lane_mask << off;
        wdata_sh = wdata << bit_off;

        shifted  = rdata_raw >> bit_off;
        unique case (func3)
            F3_LB:   rdata_ext = DATA_WIDTH'($signed(shifted[7:0]));
            F3_LH:   rdata_ext = DATA_WIDTH'($signed(shifted[15:0]));
            F3_LW:   rdata_ext = DATA_WIDTH'($signed(shifted[31:0]));
            F3_LBU:  rdata_ext = DATA_WIDTH'(shifted[7:0]);
            F3_LHU:  rdata_ext = DATA_WIDTH'(shifted[15:0]);
            F3_LWU:  rdata_ext = DATA_WIDTH'(shifted[31:0]);
            default: rdata_ext = shifted;  // ld: full word, offset is zero
        endcase
    end

endmodule

// File: rtl/ysyx_22041412_lsu.sv
// Load/store unit between MEM stage and Dcache: lane alignment, fault detection, handshakes.
// Latency: legal access accept->resp_valid >= 2 cycles (1 + Dcache wait + 1); faults 1 cycle.
// Backpressure: req_ready only in IDLE; holds Dcache request until dc_ready, response until resp_ready.
// Ports: clk, rst (sync, active-high), bus (slave modport of ysyx_22041412_lsu_if).
// Optional: define YSYX_22041412_LSU_PERF_EN for perf_load_o/perf_store_o/perf_stall_o/perf_fault_o.
module ysyx_22041412_lsu
    import ysyx_22041412_lsu_pkg::*;
#(
    parameter int  ADDR_WIDTH = 32,
    parameter int  DATA_WIDTH = 64,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic clk,
    input  logic rst,
    ysyx_22041412_lsu_if.slave bus
`ifdef YSYX_22041412_LSU_PERF_EN
    ,
    output logic [63:0] perf_load_o,
    output logic [63:0] perf_store_o,
    output logic [63:0] perf_stall_o,
    output logic [63:0] perf_fault_o
`endif
);

    localparam int OFF_WIDTH = $clog2(STRB_WIDTH);

    state_t                state_q;
    state_t                state_d;
    logic                  wen_q;
    logic [2:0]            func3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  fault_q;

    logic [2:0]            al_func3;
    logic [OFF_WIDTH-1:0]  al_off;
    logic [STRB_WIDTH-1:0] al_wstrb;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_rdata;
    logic                  al_fault;
    logic                  accept;
    logic                  dc_hs;

    // One aligner serves both phases: in IDLE it judges the incoming request
    // for faults; afterwards it works from the latched access.
    assign al_func3 = (state_q == IDLE) ? bus.req_func3_i : func3_q;
    assign al_off   = (state_q == IDLE) ? bus.req_addr_i[OFF_WIDTH-1:0] : addr_q[OFF_WIDTH-1:0];
    assign accept   = (state_q == IDLE) && bus.req_valid_i;
    assign dc_hs    = (state_q == CACHE) && bus.dc_ready_i;

    ysyx_22041412_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .func3     (al_func3),
        .off       (al_off),
        .wdata     (wdata_q),
        .rdata_raw (bus.dc_rdata_i),
        .wstrb     (al_wstrb),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata),
        .fault     (al_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        bus.req_ready_o  = 1'b0;
        bus.resp_valid_o = 1'b0;
        bus.resp_rdata_o = ZERO_WORD[DATA_WIDTH-1:0];
        bus.resp_fault_o = 1'b0;
        bus.dc_valid_o   = 1'b0;
        bus.dc_wen_o     = 1'b0;
        bus.dc_addr_o    = '0;
        bus.dc_wdata_o   = '0;
        bus.dc_wstrb_o   = '0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) state_d = al_fault ? RESP : CACHE;
            end
            CACHE: begin
                bus.dc_valid_o = 1'b1;
                bus.dc_wen_o   = wen_q;
                bus.dc_addr_o  = {addr_q[ADDR_WIDTH-1:OFF_WIDTH], {OFF_WIDTH{1'b0}}};
                if (wen_q) begin
                    bus.dc_wdata_o = al_wdata;
                    bus.dc_wstrb_o = al_wstrb;
                end
                if (bus.dc_ready_i) state_d = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.resp_rdata_o = rdata_q;
                bus.resp_fault_o = fault_q;
                if (bus.resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // rdata_q is cleared on every acceptance so stores and faults answer 0
    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q   <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            wen_q   <= bus.req_wen_i;
            func3_q <= bus.req_func3_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
            rdata_q <= '0;
            fault_q <= al_fault;
        end else if (dc_hs && !wen_q) begin
            rdata_q <= al_rdata;
        end
    end

`ifdef YSYX_22041412_LSU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_o  <= 64'd0;
            perf_store_o <= 64'd0;
            perf_stall_o <= 64'd0;
            perf_fault_o <= 64'd0;
        end else begin
            if (dc_hs && !wen_q)                      perf_load_o  <= perf_load_o + 64'd1;
            if (dc_hs && wen_q)                       perf_store_o <= perf_store_o + 64'd1;
            if ((state_q == CACHE) && !bus.dc_ready_i) perf_stall_o <= perf_stall_o + 64'd1;
            if (accept && al_fault)                   perf_fault_o <= perf_fault_o + 64'd1;
        end
    end
`endif

endmodule

// File: doc/ysyx_22041412_lsu.md
Name: ysyx_22041412_lsu

Overview:
Parametrised load/store unit placed between the MEM pipeline stage and the Dcache, succeeding the fixed 64-bit MEM wrapper.
- Generalised to DATA_WIDTH 32 or 64.
- Adds byte-lane strobes and lane shifting of store/load data.
- Detects misaligned and illegal-width accesses as faults instead of issuing them.
- Decouples the pipeline and the cache with explicit valid/ready handshakes on both request and response.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 64, cache data-bus width; legal values 32 or 64.
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width (derived; not overridden).

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_valid_i  in  1  pipeline presents an access
req_ready_o  out  1  LSU accepts an access
req_wen_i  in  1  1 = store, 0 = load
req_func3_i  in  3  RISC-V load/store funct3
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, right-justified
resp_valid_o  out  1  result available
resp_ready_i  in  1  pipeline consumes result
resp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and faults
resp_fault_o  out  1  misaligned or illegal-width access
dc_valid_o  out  1  Dcache request
dc_ready_i  in  1  Dcache done (one-cycle pulse or level)
dc_wen_o  out  1  store
dc_addr_o  out  ADDR_WIDTH  address with low log2(STRB_WIDTH) bits cleared
dc_wdata_o  out  DATA_WIDTH  lane-shifted store data
dc_wstrb_o  out  STRB_WIDTH  byte-write mask
dc_rdata_i  in  DATA_WIDTH  raw aligned line word

Behaviour:
- State machine: IDLE, CACHE, RESP.
- Reset values: state IDLE; req_ready_o 1; resp_valid_o 0; resp_rdata_o 0; resp_fault_o 0; dc_valid_o 0; dc_wen_o 0; dc_addr_o 0; dc_wdata_o 0; dc_wstrb_o 0.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch wen, func3, addr and wdata.
  - If the access is legal, go to CACHE; otherwise go directly to RESP with fault=1. No Dcache access is made for faulting requests.
- Size: func3[1:0] gives size 1/2/4/8 bytes.
  - Misaligned when addr mod size != 0.
  - Illegal when size > STRB_WIDTH: ld, sd and lwu with DATA_WIDTH=32.
  - func3=3'b111 is illegal.
- CACHE:
  - dc_valid_o=1; address, data and strobe outputs are held stable from registered values.
  - On dc_valid_o & dc_ready_i (same cycle): capture dc_rdata_i for loads, drop dc_valid_o next cycle, go to RESP.
  - No timeout.
- Lane offset: off = addr[log2(STRB_WIDTH)-1:0].
  - Store: dc_wdata_o = wdata << (8*off); dc_wstrb_o = ((1<<size)-1) << off.
  - Load: dc_wstrb_o = 0; the raw word is shifted right by 8*off, truncated to size, then extended per func3[2] (0 = sign, 1 = zero) to DATA_WIDTH.
- RESP:
  - resp_valid_o=1, with rdata/fault held until resp_valid_o & resp_ready_i, then go to IDLE.
  - The next request is accepted no earlier than the following cycle (req_ready_o=0 outside IDLE).
- Latency for a legal access, with dc_ready_i returned the cycle after dc_valid_o rises:
  - accept at cycle 0, dc_valid_o cycles 1–2, resp_valid_o cycle 3.
  - Minimum accept-to-resp_valid = 2 cycles (dc_ready_i same cycle as dc_valid_o).
- Faulting access: resp_valid_o the cycle after acceptance (1 cycle).
- Stores return resp_rdata_o=0, fault=0.
- rst in any state: outputs return to reset values at the next edge. The in-flight Dcache request is abandoned; the Dcache must tolerate dc_valid_o dropping.
- req_valid_i while not in IDLE is ignored (not latched).

Optional Feature:
Macro YSYX_22041412_LSU_PERF_EN.
- Defined: adds outputs perf_load_o[63:0], perf_store_o[63:0], perf_stall_o[63:0] and perf_fault_o[63:0].
  - perf_load_o and perf_store_o increment on each successful Dcache handshake.
  - perf_stall_o increments every cycle in CACHE with dc_ready_i=0.
  - perf_fault_o increments on each faulting acceptance.
  - All clear on rst and wrap at 2^64.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared defines header holds:
  - func3 encodings (LB..LWU, SB..SD);
  - state encodings IDLE=2'd0, CACHE=2'd1, RESP=2'd2;
  - the zero-word constant.
- Sub-module ysyx_22041412_lsu_align (purely combinational), parametrised by DATA_WIDTH: takes func3, offset, store data and raw load data; produces wstrb, shifted wdata, extended rdata and the fault flag.
- The FSM and registers stay in the top module.

Test Plan:
- DATA_WIDTH=64, sb addr 0x80000003, wdata 0xAB → dc_addr_o 0x80000000, dc_wstrb_o 8'h08, dc_wdata_o 0x00000000AB000000; resp fault=0, rdata=0.
- DATA_WIDTH=64, lh addr 0x80000006, dc_rdata_i 0x8001_0000_0000_0000 → resp_rdata_o 0xFFFFFFFFFFFF8001; lhu same → 0x0000000000008001.
- lw addr 0x80000002 → no dc_valid_o pulse; resp_valid_o 1 cycle after accept, resp_fault_o=1, rdata=0.
- DATA_WIDTH=32, ld addr 0x80000000 → fault=1; lw addr 0x80000004, dc_rdata_i 0x80000000 → rdata 0x80000000, dc_addr_o 0x80000004, wstrb 4'hF on the matching sw.
- Back-pressure: dc_ready_i delayed 5 cycles, resp_ready_i low 3 cycles → dc outputs and resp_rdata_o stable throughout, req_ready_o=0 until the cycle after the resp handshake.
- rst asserted in CACHE → next cycle dc_valid_o=0, state IDLE, req_ready_o=1; with PERF_EN, counters read 0.
